instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 195 +++++++++++++++++++
 tb/tb_instruction_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one instruction-memory read at a time,
// returns the word to decode through a registered valid/ready slot backed
// by a one-entry skid buffer, and drops responses cancelled by a flush.
// Optional feature macro: IFETCH_STALL_COUNT_EN adds a 32-bit stall_count
// output counting cycles spent in WAIT or HOLD.
module instruction_fetch #(
   parameter int unsigned N = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] PC,
   input  logic [N-1:0] PC4,
   input  logic         flush,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_ready,
   input  logic         imem_rvalid,
   input  logic [31:0]  imem_rdata,
   output logic         pc_advance,
   output logic         ir_valid,
   output logic [31:0]  ir,
   output logic [N-1:0] ir_pc,
   output logic [N-1:0] ir_pc4,
   input  logic         decode_ready
`ifdef IFETCH_STALL_COUNT_EN
   ,
   output logic [31:0]  stall_count
`endif
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

   state_e       state_q, state_d;
   logic [N-1:0] addr_q, addr_d;
   logic [N-1:0] pend_pc_q, pend_pc_d;
   logic [N-1:0] pend_pc4_q, pend_pc4_d;
   logic         discard_q, discard_d;
   logic         ir_valid_q, ir_valid_d;
   logic [31:0]  ir_q, ir_d;
   logic [N-1:0] ir_pc_q, ir_pc_d;
   logic [N-1:0] ir_pc4_q, ir_pc4_d;
   logic [31:0]  skid_data_q, skid_data_d;
   logic [N-1:0] skid_pc_q, skid_pc_d;
   logic [N-1:0] skid_pc4_q, skid_pc4_d;

   // Next-state, request outputs and output-slot/skid management
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pend_pc_d   = pend_pc_q;
      pend_pc4_d  = pend_pc4_q;
      discard_d   = discard_q;
      ir_valid_d  = ir_valid_q;
      ir_d        = ir_q;
      ir_pc_d     = ir_pc_q;
      ir_pc4_d    = ir_pc4_q;
      skid_data_d = skid_data_q;
      skid_pc_d   = skid_pc_q;
      skid_pc4_d  = skid_pc4_q;
      imem_req    = 1'b0;
      imem_addr   = addr_q;
      pc_advance  = 1'b0;

      // A consumed instruction leaves the slot unless something reloads it
      if (ir_valid_q && decode_ready) begin
         ir_valid_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            state_d = StReq;
         end
         StReq: begin
            imem_req  = 1'b1;
            imem_addr = PC;
            addr_d    = PC;
            if (imem_ready) begin
               pend_pc_d  = PC;
               pend_pc4_d = PC4;
               pc_advance = 1'b1;
               state_d    = StWait;
               // The request just accepted belongs to the flushed path
               if (flush) begin
                  discard_d = 1'b1;
               end
            end
         end
         StWait: begin
            if (imem_rvalid) begin
               if (discard_q || flush) begin
                  // Response of a cancelled fetch: drop it
                  discard_d = 1'b0;
                  state_d   = StReq;
               end else if (!ir_valid_q || decode_ready) begin
                  ir_valid_d = 1'b1;
                  ir_d       = imem_rdata;
                  ir_pc_d    = pend_pc_q;
                  ir_pc4_d   = pend_pc4_q;
                  state_d    = StReq;
               end else begin
                  skid_data_d = imem_rdata;
                  skid_pc_d   = pend_pc_q;
                  skid_pc4_d  = pend_pc4_q;
                  state_d     = StHold;
               end
            end else if (flush) begin
               discard_d = 1'b1;
            end
         end
         StHold: begin
            if (decode_ready) begin
               ir_valid_d = 1'b1;
               ir_d       = skid_data_q;
               ir_pc_d    = skid_pc_q;
               ir_pc4_d   = skid_pc4_q;
               state_d    = StReq;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Flush wins over any load into the slot; pc_advance is left alone
      if (flush) begin
         ir_valid_d  = 1'b0;
         skid_data_d = '0;
         skid_pc_d   = '0;
         skid_pc4_d  = '0;
         if (state_q == StHold) begin
            state_d = StReq;
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         pend_pc_q   <= '0;
         pend_pc4_q  <= '0;
         discard_q   <= 1'b0;
         ir_valid_q  <= 1'b0;
         ir_q        <= '0;
         ir_pc_q     <= '0;
         ir_pc4_q    <= '0;
         skid_data_q <= '0;
         skid_pc_q   <= '0;
         skid_pc4_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         pend_pc_q   <= pend_pc_d;
         pend_pc4_q  <= pend_pc4_d;
         discard_q   <= discard_d;
         ir_valid_q  <= ir_valid_d;
         ir_q        <= ir_d;
         ir_pc_q     <= ir_pc_d;
         ir_pc4_q    <= ir_pc4_d;
         skid_data_q <= skid_data_d;
         skid_pc_q   <= skid_pc_d;
         skid_pc4_q  <= skid_pc4_d;
      end
   end

   assign ir_valid = ir_valid_q;
   assign ir       = ir_q;
   assign ir_pc    = ir_pc_q;
   assign ir_pc4   = ir_pc4_q;

`ifdef IFETCH_STALL_COUNT_EN
   logic [31:0] stall_count_q, stall_count_d;

   // Count cycles waiting on memory or on decode; wraps naturally
   always_comb begin
      stall_count_d = stall_count_q;
      if (state_q == StWait || state_q == StHold) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   // Stall counter register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch. Inputs change and
// outputs are sampled around the falling clock edge.
module tb_instruction_fetch;

   localparam int unsigned N = 64;

   logic         clock;
   logic         reset;
   logic [N-1:0] PC;
   logic [N-1:0] PC4;
   logic         flush;
   logic         imem_req;
   logic [N-1:0] imem_addr;
   logic         imem_ready;
   logic         imem_rvalid;
   logic [31:0]  imem_rdata;
   logic         pc_advance;
   logic         ir_valid;
   logic [31:0]  ir;
   logic [N-1:0] ir_pc;
   logic [N-1:0] ir_pc4;
   logic         decode_ready;
`ifdef IFETCH_STALL_COUNT_EN
   logic [31:0]  stall_count;
`endif

   int n_checks;
   int n_pass;

   instruction_fetch #(.N(N)) dut (
      .clock        (clock),
      .reset        (reset),
      .PC           (PC),
      .PC4          (PC4),
      .flush        (flush),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .pc_advance   (pc_advance),
      .ir_valid     (ir_valid),
      .ir           (ir),
      .ir_pc        (ir_pc),
      .ir_pc4       (ir_pc4),
      .decode_ready (decode_ready)
`ifdef IFETCH_STALL_COUNT_EN
      ,
      .stall_count  (stall_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      reset        = 1'b0;
      PC           = 64'h0;
      PC4          = 64'h4;
      flush        = 1'b0;
      imem_ready   = 1'b0;
      imem_rvalid  = 1'b0;
      imem_rdata   = 32'h0;
      decode_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clock);
      check_eq("rst_imem_req", {63'b0, imem_req}, 64'h0);
      check_eq("rst_imem_addr", imem_addr, 64'h0);
      check_eq("rst_pc_advance", {63'b0, pc_advance}, 64'h0);
      check_eq("rst_ir_valid", {63'b0, ir_valid}, 64'h0);
      check_eq("rst_ir", {32'b0, ir}, 64'h0);
      check_eq("rst_ir_pc", ir_pc, 64'h0);
      check_eq("rst_ir_pc4", ir_pc4, 64'h0);

      // Basic fetch of 0x8B020020 from PC 0
      reset = 1'b1;
      @(negedge clock);
      check_eq("req_after_idle", {63'b0, imem_req}, 64'h1);
      check_eq("req_addr0", imem_addr, 64'h0);
      imem_ready = 1'b1;
      #1 check_eq("pc_adv_pulse", {63'b0, pc_advance}, 64'h1);
      @(negedge clock);
      imem_ready = 1'b0;
      PC  = 64'h4;
      PC4 = 64'h8;
      #1;
      check_eq("wait_pc_adv0", {63'b0, pc_advance}, 64'h0);
      check_eq("wait_req0", {63'b0, imem_req}, 64'h0);
      check_eq("wait_addr_held", imem_addr, 64'h0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h8B02_0020;
      @(negedge clock);
      imem_rvalid = 1'b0;
      check_eq("f1_ir_valid", {63'b0, ir_valid}, 64'h1);
      check_eq("f1_ir", {32'b0, ir}, 64'h8B02_0020);
      check_eq("f1_ir_pc", ir_pc, 64'h0);
      check_eq("f1_ir_pc4", ir_pc4, 64'h4);

      // Memory stalls the request for 5 cycles
      for (int i = 0; i < 5; i++) begin
         check_eq("stall_req", {63'b0, imem_req}, 64'h1);
         check_eq("stall_addr", imem_addr, 64'h4);
         check_eq("stall_no_adv", {63'b0, pc_advance}, 64'h0);
         check_eq("stall_ir_stable", {32'b0, ir}, 64'h8B02_0020);
         @(negedge clock);
      end
      imem_ready = 1'b1;
      #1 check_eq("stall_accept_adv", {63'b0, pc_advance}, 64'h1);

      // Second response lands in the skid while decode is blocked
      @(negedge clock);
      imem_ready  = 1'b0;
      PC          = 64'h8;
      PC4         = 64'hC;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h1111_1111;
      @(negedge clock);
      imem_rvalid = 1'b0;
      check_eq("hold_ir_stable", {32'b0, ir}, 64'h8B02_0020);
      check_eq("hold_ir_pc", ir_pc, 64'h0);
      check_eq("hold_ir_valid", {63'b0, ir_valid}, 64'h1);
      check_eq("hold_no_req", {63'b0, imem_req}, 64'h0);
      decode_ready = 1'b1;
      @(negedge clock);
      check_eq("skid_ir", {32'b0, ir}, 64'h1111_1111);
      check_eq("skid_ir_pc", ir_pc, 64'h4);
      check_eq("skid_ir_pc4", ir_pc4, 64'h8);
      check_eq("skid_ir_valid", {63'b0, ir_valid}, 64'h1);
      @(negedge clock);
      check_eq("drained_valid", {63'b0, ir_valid}, 64'h0);
      decode_ready = 1'b0;

      // Flush while waiting on PC 0x40: response is dropped
      PC         = 64'h40;
      PC4        = 64'h44;
      imem_ready = 1'b1;
      #1 check_eq("fl_req_addr", imem_addr, 64'h40);
      @(negedge clock);
      imem_ready = 1'b0;
      flush      = 1'b1;
      @(negedge clock);
      flush       = 1'b0;
      PC          = 64'h80;
      PC4         = 64'h84;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clock);
      imem_rvalid = 1'b0;
      check_eq("fl_dropped_valid", {63'b0, ir_valid}, 64'h0);
      check_eq("fl_new_req", {63'b0, imem_req}, 64'h1);
      check_eq("fl_new_addr", imem_addr, 64'h80);
      imem_ready = 1'b1;
      @(negedge clock);
      imem_ready  = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h2222_2222;
      @(negedge clock);
      imem_rvalid = 1'b0;
      check_eq("fl_next_ir", {32'b0, ir}, 64'h2222_2222);
      check_eq("fl_next_ir_pc", ir_pc, 64'h80);
      check_eq("fl_next_ir_pc4", ir_pc4, 64'h84);
      check_eq("fl_next_valid", {63'b0, ir_valid}, 64'h1);

      // Stray response outside WAIT is ignored
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h3333_3333;
      @(negedge clock);
      imem_rvalid = 1'b0;
      check_eq("stray_ir", {32'b0, ir}, 64'h2222_2222);
      check_eq("stray_req", {63'b0, imem_req}, 64'h1);

      // Flush clears a held instruction
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check_eq("flush_clears_valid", {63'b0, ir_valid}, 64'h0);

      // Asynchronous reset while waiting
      imem_ready = 1'b1;
      @(negedge clock);
      imem_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_eq("ar_req", {63'b0, imem_req}, 64'h0);
      check_eq("ar_addr", imem_addr, 64'h0);
      check_eq("ar_pc_adv", {63'b0, pc_advance}, 64'h0);
      check_eq("ar_valid", {63'b0, ir_valid}, 64'h0);
      check_eq("ar_ir", {32'b0, ir}, 64'h0);
      check_eq("ar_ir_pc", ir_pc, 64'h0);
      check_eq("ar_ir_pc4", ir_pc4, 64'h0);
`ifdef IFETCH_STALL_COUNT_EN
      check_eq("ar_stall_count", {32'b0, stall_count}, 64'h0);
`endif
      @(negedge clock);
      reset = 1'b1;
      PC    = 64'h100;
      PC4   = 64'h104;
      @(negedge clock);
      check_eq("post_rst_addr", imem_addr, 64'h100);
      imem_ready = 1'b1;
      @(negedge clock);
      imem_ready = 1'b0;
      repeat (2) @(negedge clock);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h4444_4444;
      @(negedge clock);
      imem_rvalid = 1'b0;
      check_eq("post_rst_ir", {32'b0, ir}, 64'h4444_4444);
      check_eq("post_rst_ir_pc", ir_pc, 64'h100);
      check_eq("post_rst_valid", {63'b0, ir_valid}, 64'h1);
`ifdef IFETCH_STALL_COUNT_EN
      check_eq("stall_count_3", {32'b0, stall_count}, 64'h3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
